// File: rtl/sequenciador_pc.sv
// Instruction fetch sequencer: fetches one word per PC, presents it to the consumer,
// then picks the next PC from halt/jump/branch/sequential.
module sequenciador_pc #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_offset,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  instr_valid,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  halted,
  output logic                  erro_fetch
);

  typedef enum logic [1:0] {BUSCA, EMITE, PARADO, ERRO} state_t;

  localparam int         OFF_WIDTH   = ADDR_WIDTH + 16;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [31:0]           instr_reg, instr_next;

  logic [OFF_WIDTH-1:0]  off_wide;
  logic [ADDR_WIDTH-1:0] pc_incr;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  unused_off_bits;

  // Sign-extend past the PC width, then keep only the low bits so the add wraps.
  assign off_wide        = {{ADDR_WIDTH{branch_offset[15]}}, branch_offset};
  assign unused_off_bits = ^off_wide[OFF_WIDTH-1:ADDR_WIDTH];
  assign pc_incr         = pc_reg + ADDR_WIDTH'(1);
  assign branch_target   = pc_incr + off_wide[ADDR_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= BUSCA;
      pc_reg    <= RESET_ADDR;
      cnt_reg   <= '0;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      instr_reg <= instr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    instr_next = instr_reg;
    case (state_reg)
      BUSCA: begin
        // An ack on the last allowed cycle still counts as a successful fetch.
        if (mem_ack) begin
          instr_next = mem_data;
          cnt_next   = '0;
          state_next = EMITE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
            state_next = ERRO;
          end
        end
      end
      EMITE: begin
        if (!stall) begin
          if (halt) begin
            state_next = PARADO;
          end else begin
            state_next = BUSCA;
            if (jump_en) begin
              pc_next = jump_addr;
            end else if (branch_taken) begin
              pc_next = branch_target;
            end else begin
              pc_next = pc_incr;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    erro_fetch  = 1'b0;
    case (state_reg)
      BUSCA:   mem_req     = 1'b1;
      EMITE:   instr_valid = 1'b1;
      PARADO:  halted      = 1'b1;
      ERRO:    erro_fetch  = 1'b1;
      default: begin
      end
    endcase
  end

  assign mem_addr  = pc_reg;
  assign pc_out    = pc_reg;
  assign instr_out = instr_reg;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Randomized bench for sequenciador_pc: a PC model predicts issued (pc, word) pairs,
// a monitor compares them whenever a new instruction is presented.
module tb_sequenciador_pc;

  localparam int AW      = 13;
  localparam int TIMEOUT = 15;

  logic          clock;
  logic          reset;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_data;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          branch_taken;
  logic [15:0]   branch_offset;
  logic          stall;
  logic          halt;
  logic          instr_valid;
  logic [31:0]   instr_out;
  logic [AW-1:0] pc_out;
  logic          halted;
  logic          erro_fetch;

  sequenciador_pc #(.ADDR_WIDTH(AW), .RESET_ADDR('0), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .stall(stall), .halt(halt),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .halted(halted), .erro_fetch(erro_fetch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   data;
  } issue_t;

  issue_t        sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a rising instr_valid marks a newly issued instruction.
  initial begin
    logic   prev_valid;
    issue_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_valid === 1'b1 && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got pc %0h word %0h expected no issue", pc_out, instr_out);
        end else begin
          e = sb.pop_front();
          chk("issue_pc", 32'(pc_out), 32'(e.pc));
          chk("issue_word", instr_out, e.data);
          $display("issue pc=%0h word=%08h", pc_out, instr_out);
        end
      end
      prev_valid = (instr_valid === 1'b1);
    end
  end

  // Each task is entered at a negedge with the DUT outputs settled and inputs unset.
  task automatic do_reset();
    reset    = 1'b1;
    mem_ack  = 1'b1;
    mem_data = $urandom;
    stall = 1'b0; halt = 1'b0; jump_en = 1'b0; branch_taken = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b0;
    mem_ack = 1'b0;
    m_pc    = '0;
    sb.delete();
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_erro", 32'(erro_fetch), 32'd0);
    $display("reset released");
  endtask

  task automatic fetch(input int d, input logic [31:0] data);
    for (int i = 0; i <= d; i++) begin
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
      mem_ack  = (i == d);
      mem_data = (i == d) ? data : $urandom;
      if (i == d) sb.push_back('{pc: m_pc, data: data});
      @(negedge clock);
    end
    mem_ack = 1'b0;
  endtask

  task automatic emit(input int stalls, input logic h, input logic j, input logic b,
                      input logic [AW-1:0] ja, input logic [15:0] off);
    int t;
    for (int s = 0; s < stalls; s++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(mem_req), 32'd0);
      stall = 1'b1;
      halt = 1'($urandom); jump_en = 1'($urandom); branch_taken = 1'($urandom);
      jump_addr = AW'($urandom); branch_offset = 16'($urandom);
      mem_ack = 1'($urandom); mem_data = $urandom;
      @(negedge clock);
    end
    chk("emit_valid", 32'(instr_valid), 32'd1);
    chk("emit_req", 32'(mem_req), 32'd0);
    stall = 1'b0; halt = h; jump_en = j; branch_taken = b;
    jump_addr = ja; branch_offset = off;
    mem_ack = 1'($urandom); mem_data = $urandom;
    @(negedge clock);
    halt = 1'b0; jump_en = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0;
    $display("emit stalls=%0d halt=%0b jump=%0b branch=%0b ja=%0h off=%0h", stalls, h, j, b, ja, off);
    if (!h) begin
      if (j) begin
        m_pc = ja;
      end else if (b) begin
        t    = int'(m_pc) + 1 + int'($signed(off));
        m_pc = t[AW-1:0];
      end else begin
        m_pc = m_pc + AW'(1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_data = '0;
    jump_en = 1'b0; jump_addr = '0; branch_taken = 1'b0; branch_offset = '0;
    stall = 1'b0; halt = 1'b0; m_pc = '0;
    @(negedge clock);
    do_reset();

    // Sequential back-to-back issue, word = address
    for (int k = 0; k < 4; k++) begin
      fetch(0, 32'(k));
      emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    // Stall with ignored controls, then PC+1
    fetch(0, $urandom);
    emit(3, 1'b0, 1'b0, 1'b0, '0, '0);
    // Jump beats a simultaneous taken branch
    fetch(1, $urandom);
    emit(0, 1'b0, 1'b1, 1'b1, 13'h1ABC, 16'h0010);
    fetch(2, $urandom);
    emit(0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Branch wrap below zero and sequential wrap past all-ones
    do_reset();
    fetch(0, $urandom); emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch(0, $urandom); emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch(0, $urandom); emit(0, 1'b0, 1'b0, 1'b1, '0, 16'hFFFC);
    fetch(0, $urandom); emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    // Ack on the final allowed fetch cycle
    fetch(TIMEOUT - 1, $urandom);
    emit(1, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      fetch(int'($urandom_range(0, TIMEOUT - 1)), $urandom);
      emit(int'($urandom_range(0, 3)), 1'b0, 1'($urandom), 1'($urandom),
           AW'($urandom), 16'($urandom));
    end

    // Fetch timeout
    fetch(0, $urandom);
    emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      chk("to_erro_early", 32'(erro_fetch), 32'd0);
      mem_ack = 1'b0;
      @(negedge clock);
    end
    for (int i = 0; i < 3; i++) begin
      chk("to_erro", 32'(erro_fetch), 32'd1);
      chk("to_req_off", 32'(mem_req), 32'd0);
      chk("to_valid", 32'(instr_valid), 32'd0);
      chk("to_addr", 32'(mem_addr), 32'(m_pc));
      mem_ack = 1'b1; mem_data = $urandom;
      @(negedge clock);
    end
    $display("timeout reached at pc=%0h", m_pc);
    do_reset();

    // Halt, then reset
    fetch(1, $urandom);
    emit(1, 1'b1, 1'b1, 1'b1, 13'h0055, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(mem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      mem_ack = 1'($urandom); mem_data = $urandom;
      @(negedge clock);
    end
    $display("halted at pc=%0h", m_pc);
    do_reset();

    // Reset mid-fetch with an ack pending in the reset cycle
    fetch(0, $urandom); emit(0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b0;
      @(negedge clock);
    end
    do_reset();
    // Reset while presenting an instruction
    fetch(0, 32'hDEADBEEF);
    @(negedge clock);
    do_reset();
    fetch(0, $urandom);
    emit(0, 1'b0, 1'b0, 1'b0, '0, '0);

    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_pc.md
SEQUENCIADOR_PC -- requirements
Module: sequenciador_pc

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 13, giving the width of the instruction address and PC.
- REQ-002 SHALL have parameter RESET_ADDR, default 0, giving the PC value loaded at reset.
- REQ-003 SHALL have parameter TIMEOUT, default 15, giving the maximum cycles in BUSCA awaiting mem_ack (range 1..255).
- REQ-004 SHALL have port clock, input, 1 bit; the single clock, and all state changes on its rising edge.
- REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
- REQ-006 SHALL have port mem_req, output, 1 bit; instruction memory read request.
- REQ-007 SHALL have port mem_addr, output, ADDR_WIDTH bits; read address, equal to the current PC.
- REQ-008 SHALL have port mem_ack, input, 1 bit; memory read data valid.
- REQ-009 SHALL have port mem_data, input, 32 bits; instruction word from memory.
- REQ-010 SHALL have port jump_en, input, 1 bit; the issued instruction is a JUMP.
- REQ-011 SHALL have port jump_addr, input, ADDR_WIDTH bits; absolute jump target, extracted from the 26-bit immediate.
- REQ-012 SHALL have port branch_taken, input, 1 bit; the issued instruction is a taken conditional branch.
- REQ-013 SHALL have port branch_offset, input, 16 bits; signed, word-granular branch offset.
- REQ-014 SHALL have port stall, input, 1 bit; the consumer cannot accept the issued instruction.
- REQ-015 SHALL have port halt, input, 1 bit; the issued instruction is HALT.
- REQ-016 SHALL have port instr_valid, output, 1 bit; instr_out and pc_out are valid.
- REQ-017 SHALL have port instr_out, output, 32 bits; latched instruction word.
- REQ-018 SHALL have port pc_out, output, ADDR_WIDTH bits; address of instr_out.
- REQ-019 SHALL have port halted, output, 1 bit; the sequencer is stopped by HALT.
- REQ-020 SHALL have port erro_fetch, output, 1 bit; the sequencer is stopped by fetch timeout.

Function
- REQ-021 SHALL implement the four states BUSCA, EMITE, PARADO and ERRO.
- REQ-022 BUSCA SHALL drive mem_req=1 with mem_addr=PC held stable until mem_ack is sampled high.
- REQ-023 In BUSCA with mem_ack=1, the block SHALL latch mem_data into instr_out, clear the timeout counter and go to EMITE.
- REQ-024 In BUSCA with mem_ack=0, the block SHALL increment the timeout counter; when the counter reaches TIMEOUT, it SHALL go to ERRO.
- REQ-025 When mem_ack arrives in the same cycle the counter would reach TIMEOUT, mem_ack SHALL win.
- REQ-026 EMITE SHALL drive instr_valid=1 and mem_req=0, with instr_out and pc_out held constant.
- REQ-027 In EMITE with stall=1, the block SHALL remain in EMITE and SHALL ignore jump_en, branch_taken and halt.
- REQ-028 In EMITE with stall=0, the next-PC priority SHALL be: halt (PC unchanged, go to PARADO) > jump_en (PC=jump_addr) > branch_taken (PC=PC+1+sext(branch_offset)) > PC+1; all cases except halt SHALL go to BUSCA.
- REQ-029 All PC arithmetic SHALL be modulo 2^ADDR_WIDTH.
- REQ-030 The branch offset SHALL be sign-extended and then truncated to ADDR_WIDTH, and PC+1 SHALL wrap from all-ones to 0.
- REQ-031 PARADO SHALL drive halted=1 with mem_req=0 and instr_valid=0, and SHALL exit only by reset.
- REQ-032 ERRO SHALL drive erro_fetch=1 with mem_req=0 and instr_valid=0, SHALL hold mem_addr at the failing PC, and SHALL exit only by reset.
- REQ-033 Minimum issue rate SHALL be one instruction per 2 cycles (1-cycle ack plus 1-cycle EMITE).
- REQ-034 A mem_ack in any state other than BUSCA SHALL be ignored.

Reset
- REQ-035 While reset=1 at a clock edge, the block SHALL set PC=RESET_ADDR, state=BUSCA, timeout counter=0, instr_out=0, instr_valid=0, halted=0 and erro_fetch=0.
- REQ-036 mem_req SHALL read 1 in the first cycle after reset is released.
- REQ-037 A reset asserted mid-fetch, in EMITE, in PARADO or in ERRO SHALL abandon all state and return to the REQ-035 values.
- REQ-038 A pending mem_ack in the reset cycle SHALL be discarded.

Verification
- REQ-039 Sequential fetch: reset, then mem_ack=1 every BUSCA cycle with data=addr -> instr_valid every 2nd cycle, pc_out 0,1,2,3.
- REQ-040 Jump: with pc_out=5, EMITE, jump_en=1, jump_addr=0x1ABC, branch_taken=1 -> next mem_addr=0x1ABC.
- REQ-041 Branch wrap: with pc_out=2, branch_offset=0xFFFC (-4) -> next mem_addr=0x1FFF; with pc_out=0x1FFF and sequential flow -> next mem_addr=0.
- REQ-042 Stall: stall=1 for 3 cycles in EMITE, with jump_en pulsed during the stall -> instr_valid held 4 cycles, the pulse ignored, then PC+1.
- REQ-043 Timeout: mem_ack held 0 -> erro_fetch=1 after exactly 15 BUSCA cycles, mem_req=0; an ack on cycle 15 -> EMITE, no error.
- REQ-044 Halt, then reset: halt=1 in EMITE -> halted=1, no further mem_req; reset -> mem_addr=RESET_ADDR, halted=0.
